// File: rtl/oam_dma.sv
// Sprite DMA engine: on a CPU write to $4014 it halts the CPU and copies one
// 256-byte page into sprite RAM through repeated $2004 writes.
module oam_dma #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en,
  input  logic [7:0]  bus_data_in,
  output logic        dma_active,
  output logic        cpu_halt,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data_out,
  output logic        dma_write_en,
  output logic        dma_read_en,
  output logic        dma_done
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

  // Index of the final WAIT cycle; unused when reads return in the same cycle.
  localparam logic [1:0] WAIT_LAST = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

  state_t      state;
  state_t      next_state;
  logic [7:0]  page;
  logic [7:0]  index;
  logic [7:0]  data_latch;
  logic [1:0]  wait_cnt;
  logic        done_q;
  logic        trigger;
  logic        wait_last;
  logic        last_byte;

  assign trigger   = cpu_write_en && (cpu_addr == 16'h4014);
  assign wait_last = (wait_cnt == WAIT_LAST);
  assign last_byte = (index == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (trigger) next_state = READ;
      READ:    next_state = (RD_LATENCY == 0) ? WRITE : WAIT;
      WAIT:    if (wait_last) next_state = WRITE;
      WRITE:   next_state = last_byte ? IDLE : READ;
      default: next_state = IDLE;
    endcase
  end

  // Page/index/latch bookkeeping; triggers outside IDLE are deliberately ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page       <= 8'h00;
      index      <= 8'h00;
      data_latch <= 8'h00;
      wait_cnt   <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == WRITE) && last_byte;
      case (state)
        IDLE: begin
          if (trigger) begin
            page  <= cpu_data_in;
            index <= 8'h00;
          end
        end
        READ: begin
          wait_cnt <= 2'd0;
          if (RD_LATENCY == 0) data_latch <= bus_data_in;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_last) data_latch <= bus_data_in;
        end
        WRITE: begin
          if (!last_byte) index <= index + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dma_active   = 1'b0;
    cpu_halt     = 1'b0;
    dma_addr     = 16'h0000;
    dma_data_out = 8'h00;
    dma_write_en = 1'b0;
    dma_read_en  = 1'b0;
    dma_done     = done_q;
    case (state)
      READ: begin
        dma_active  = 1'b1;
        cpu_halt    = 1'b1;
        dma_addr    = {page, index};
        dma_read_en = 1'b1;
      end
      WAIT: begin
        dma_active = 1'b1;
        cpu_halt   = 1'b1;
        dma_addr   = {page, index};
      end
      WRITE: begin
        dma_active   = 1'b1;
        cpu_halt     = 1'b1;
        dma_addr     = 16'h2004;
        dma_data_out = data_latch;
        dma_write_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: models CPU RAM, the read pipeline and sprite RAM, and
// checks DMA write traffic against a scoreboard of expected bytes.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_in = 8'h00;
  logic        cpu_write_en = 1'b0;
  logic        ext_en = 1'b0;
  logic        ext_we;

  logic        dma_active, cpu_halt, dma_write_en, dma_read_en, dma_done;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_out, bus_data_in;

  logic        l0_active, l0_halt, l0_we, l0_re, l0_done;
  logic [15:0] l0_addr;
  logic [7:0]  l0_data, l0_rdata;
  logic        l3_active, l3_halt, l3_we, l3_re, l3_done;
  logic [15:0] l3_addr;
  logic [7:0]  l3_data, l3_rdata;

  logic [7:0]  cpu_ram [0:65535];
  logic [7:0]  sprite  [0:255];
  logic [7:0]  oam_addr = 8'h00;
  logic [7:0]  rd_pipe = 8'h00;
  logic [7:0]  p3a = 8'h00, p3b = 8'h00, p3c = 8'h00;

  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;

  int cmp_count = 0;
  int err_count = 0;
  int active_cnt, done_cnt, overlap_cnt, act0_cnt, act3_cnt;
  logic [7:0]  exp_q[$];
  logic [23:0] obs_q[$];
  logic [7:0]  obs0_q[$];
  logic [7:0]  obs3_q[$];

  always #5 clk = ~clk;

  assign ext_we = cpu_write_en & ext_en;

  oam_dma #(.RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_write_en(cpu_write_en), .bus_data_in(bus_data_in),
    .dma_active(dma_active), .cpu_halt(cpu_halt), .dma_addr(dma_addr),
    .dma_data_out(dma_data_out), .dma_write_en(dma_write_en),
    .dma_read_en(dma_read_en), .dma_done(dma_done)
  );

  oam_dma #(.RD_LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_write_en(ext_we), .bus_data_in(l0_rdata),
    .dma_active(l0_active), .cpu_halt(l0_halt), .dma_addr(l0_addr),
    .dma_data_out(l0_data), .dma_write_en(l0_we),
    .dma_read_en(l0_re), .dma_done(l0_done)
  );

  oam_dma #(.RD_LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_write_en(ext_we), .bus_data_in(l3_rdata),
    .dma_active(l3_active), .cpu_halt(l3_halt), .dma_addr(l3_addr),
    .dma_data_out(l3_data), .dma_write_en(l3_we),
    .dma_read_en(l3_re), .dma_done(l3_done)
  );

  // Bus mux and decoder model: $2003 sets the sprite address, $2004 writes and increments it.
  assign bus_addr    = dma_active ? dma_addr : cpu_addr;
  assign bus_wdata   = dma_active ? dma_data_out : cpu_data_in;
  assign bus_we      = dma_active ? dma_write_en : cpu_write_en;
  assign bus_data_in = rd_pipe;
  assign l0_rdata    = cpu_ram[l0_addr];
  assign l3_rdata    = p3c;

  always @(posedge clk) begin
    rd_pipe <= cpu_ram[dma_addr];
    p3a <= cpu_ram[l3_addr];
    p3b <= p3a;
    p3c <= p3b;
    if (bus_we && bus_addr == 16'h2003) begin
      oam_addr <= bus_wdata;
    end else if (bus_we && bus_addr == 16'h2004) begin
      sprite[oam_addr] <= bus_wdata;
      oam_addr <= oam_addr + 8'd1;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
    if (dma_active) active_cnt++;
    if (dma_done) done_cnt++;
    if (dma_write_en) obs_q.push_back({dma_addr, dma_data_out});
    if (dma_write_en && dma_read_en) overlap_cnt++;
    if (l0_we && l0_re) overlap_cnt++;
    if (l3_we && l3_re) overlap_cnt++;
    if (l0_active) act0_cnt++;
    if (l3_active) act3_cnt++;
    if (l0_we) obs0_q.push_back(l0_data);
    if (l3_we) obs3_q.push_back(l3_data);
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    cpu_addr     = addr;
    cpu_data_in  = data;
    cpu_write_en = 1'b1;
    tick();
    cpu_write_en = 1'b0;
    cpu_addr     = 16'h0000;
    cpu_data_in  = 8'h00;
  endtask

  task automatic run_until_done(input int budget, output bit seen);
    int start;
    start = done_cnt;
    seen  = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_obs();
    exp_q.delete();
    obs_q.delete();
    active_cnt  = 0;
    done_cnt    = 0;
    overlap_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    cmp_count++;
    if ({dma_active, cpu_halt, dma_addr, dma_data_out, dma_write_en, dma_read_en, dma_done} !== 29'd0) begin
      err_count++;
      $display("[TB] FAIL reset_outputs: got act=%b halt=%b addr=%h data=%h we=%b re=%b done=%b, want all 0",
               dma_active, cpu_halt, dma_addr, dma_data_out, dma_write_en, dma_read_en, dma_done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_page_copy();
    bit seen;
    logic [23:0] o;
    for (int i = 0; i < 256; i++) cpu_ram[16'h0200 + i] = 8'(i) ^ 8'h5A;
    clear_obs();
    cpu_write(16'h2003, 8'h00);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ 8'h5A);
    cpu_write(16'h4014, 8'h02);
    cmp_count++;
    if ({dma_addr, dma_read_en, dma_write_en} !== {16'h0200, 1'b1, 1'b0}) begin
      err_count++;
      $display("[TB] FAIL cyc0_read: got addr=%h re=%b we=%b, want 0200 1 0", dma_addr, dma_read_en, dma_write_en);
    end
    tick();
    cmp_count++;
    if ({dma_addr, dma_read_en, dma_write_en, dma_active} !== {16'h0200, 1'b0, 1'b0, 1'b1}) begin
      err_count++;
      $display("[TB] FAIL cyc1_wait: got addr=%h re=%b we=%b act=%b, want 0200 0 0 1", dma_addr, dma_read_en, dma_write_en, dma_active);
    end
    tick();
    cmp_count++;
    if ({dma_addr, dma_read_en, dma_write_en, dma_data_out} !== {16'h2004, 1'b0, 1'b1, 8'h5A}) begin
      err_count++;
      $display("[TB] FAIL cyc2_write: got addr=%h re=%b we=%b data=%h, want 2004 0 1 5a", dma_addr, dma_read_en, dma_write_en, dma_data_out);
    end
    tick();
    cmp_count++;
    if ({dma_addr, dma_read_en, dma_write_en} !== {16'h0201, 1'b1, 1'b0}) begin
      err_count++;
      $display("[TB] FAIL cyc3_read: got addr=%h re=%b we=%b, want 0201 1 0", dma_addr, dma_read_en, dma_write_en);
    end
    run_until_done(3000, seen);
    cmp_count++;
    if (!seen) begin
      err_count++;
      $display("[TB] FAIL copy_done: got no dma_done pulse, want one within budget");
    end
    cmp_count++;
    if (dma_active !== 1'b0) begin
      err_count++;
      $display("[TB] FAIL done_idle: got dma_active=%b in done cycle, want 0", dma_active);
    end
    tick(); tick(); tick();
    cmp_count++;
    if (active_cnt != 768 || done_cnt != 1 || overlap_cnt != 0) begin
      err_count++;
      $display("[TB] FAIL copy_timing: got active=%0d done=%0d overlap=%0d, want 768 1 0", active_cnt, done_cnt, overlap_cnt);
    end
    cmp_count++;
    if (obs_q.size() != exp_q.size()) begin
      err_count++;
      $display("[TB] FAIL copy_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      cmp_count++;
      if (o !== {16'h2004, exp_q[0]}) begin
        err_count++;
        $display("[TB] FAIL copy_write: got addr=%h data=%h, want 2004 %h", o[23:8], o[7:0], exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < 256; i++) begin
      cmp_count++;
      if (sprite[i] !== (8'(i) ^ 8'h5A)) begin
        err_count++;
        $display("[TB] FAIL copy_sprite[%0d]: got %h, want %h", i, sprite[i], 8'(i) ^ 8'h5A);
      end
    end
  endtask

  task automatic test_offset();
    bit seen;
    logic [7:0] want;
    for (int i = 0; i < 256; i++) cpu_ram[16'h0300 + i] = 8'(i * 7 + 3);
    clear_obs();
    cpu_write(16'h2003, 8'h80);
    cpu_write(16'h4014, 8'h03);
    run_until_done(3000, seen);
    cmp_count++;
    if (!seen || active_cnt != 768) begin
      err_count++;
      $display("[TB] FAIL offset_done: got seen=%b active=%0d, want 1 768", seen, active_cnt);
    end
    tick();
    for (int i = 0; i < 256; i++) begin
      want = 8'(i * 7 + 3);
      cmp_count++;
      if (sprite[(8'h80 + i) & 8'hFF] !== want) begin
        err_count++;
        $display("[TB] FAIL offset_sprite[%0d]: got %h, want %h", (8'h80 + i) & 8'hFF, sprite[(8'h80 + i) & 8'hFF], want);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int done_before, writes_before;
    logic [23:0] o;
    clear_obs();
    cpu_write(16'h2003, 8'h00);
    cpu_write(16'h4014, 8'h02);
    for (int c = 0; c < 99; c++) tick();
    #2 rst = 1'b1;
    #1;
    cmp_count++;
    if ({dma_active, cpu_halt, dma_addr, dma_data_out, dma_write_en, dma_read_en, dma_done} !== 29'd0) begin
      err_count++;
      $display("[TB] FAIL reset_async: got act=%b halt=%b addr=%h data=%h we=%b re=%b done=%b, want all 0",
               dma_active, cpu_halt, dma_addr, dma_data_out, dma_write_en, dma_read_en, dma_done);
    end
    done_before   = done_cnt;
    writes_before = obs_q.size();
    tick(); tick(); tick();
    rst = 1'b0;
    tick(); tick();
    cmp_count++;
    if (done_cnt != done_before || obs_q.size() != writes_before) begin
      err_count++;
      $display("[TB] FAIL reset_quiet: got done=%0d writes=%0d, want %0d %0d", done_cnt, obs_q.size(), done_before, writes_before);
    end
    for (int i = 0; i < 256; i++) cpu_ram[16'h0200 + i] = ~8'(i);
    clear_obs();
    cpu_write(16'h2003, 8'h00);
    for (int i = 0; i < 256; i++) exp_q.push_back(~8'(i));
    cpu_write(16'h4014, 8'h02);
    cmp_count++;
    if ({dma_addr, dma_read_en} !== {16'h0200, 1'b1}) begin
      err_count++;
      $display("[TB] FAIL restart_addr: got addr=%h re=%b, want 0200 1", dma_addr, dma_read_en);
    end
    run_until_done(3000, seen);
    cmp_count++;
    if (!seen || active_cnt != 768 || obs_q.size() != 256) begin
      err_count++;
      $display("[TB] FAIL restart_done: got seen=%b active=%0d writes=%0d, want 1 768 256", seen, active_cnt, obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      cmp_count++;
      if (o !== {16'h2004, exp_q[0]}) begin
        err_count++;
        $display("[TB] FAIL restart_write: got addr=%h data=%h, want 2004 %h", o[23:8], o[7:0], exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    tick();
    for (int i = 0; i < 256; i += 17) begin
      cmp_count++;
      if (sprite[i] !== ~8'(i)) begin
        err_count++;
        $display("[TB] FAIL restart_sprite[%0d]: got %h, want %h", i, sprite[i], ~8'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    logic [23:0] o;
    for (int i = 0; i < 256; i++) cpu_ram[16'h0400 + i] = 8'(i) ^ 8'hC3;
    for (int i = 0; i < 256; i++) cpu_ram[16'h0700 + i] = 8'hEE;
    clear_obs();
    cpu_write(16'h2003, 8'h00);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ 8'hC3);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i * 7 + 3));
    cpu_write(16'h4014, 8'h04);
    for (int c = 0; c < 50; c++) tick();
    cpu_write(16'h4014, 8'h07);
    run_until_done(3000, seen);
    cmp_count++;
    if (!seen || active_cnt != 768) begin
      err_count++;
      $display("[TB] FAIL retrig_first: got seen=%b active=%0d, want 1 768", seen, active_cnt);
    end
    cpu_write(16'h4014, 8'h03);
    cmp_count++;
    if ({dma_active, dma_addr, dma_read_en} !== {1'b1, 16'h0300, 1'b1}) begin
      err_count++;
      $display("[TB] FAIL retrig_done_cycle: got act=%b addr=%h re=%b, want 1 0300 1", dma_active, dma_addr, dma_read_en);
    end
    run_until_done(3000, seen);
    cmp_count++;
    if (!seen || active_cnt != 1536 || done_cnt != 2 || obs_q.size() != 512) begin
      err_count++;
      $display("[TB] FAIL retrig_second: got seen=%b active=%0d done=%0d writes=%0d, want 1 1536 2 512",
               seen, active_cnt, done_cnt, obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      cmp_count++;
      if (o !== {16'h2004, exp_q[0]}) begin
        err_count++;
        $display("[TB] FAIL retrig_write: got addr=%h data=%h, want 2004 %h", o[23:8], o[7:0], exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_latency();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) cpu_ram[16'h0200 + i] = 8'(i) ^ 8'h5A;
    clear_obs();
    act0_cnt = 0;
    act3_cnt = 0;
    obs0_q.delete();
    obs3_q.delete();
    ext_en = 1'b1;
    cpu_write(16'h4014, 8'h02);
    ext_en = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!dma_active && !l0_active && !l3_active) break;
    end
    cmp_count++;
    if (act0_cnt != 512 || act3_cnt != 1280 || overlap_cnt != 0) begin
      err_count++;
      $display("[TB] FAIL latency_cycles: got lat0=%0d lat3=%0d overlap=%0d, want 512 1280 0", act0_cnt, act3_cnt, overlap_cnt);
    end
    cmp_count++;
    if (obs0_q.size() != 256 || obs3_q.size() != 256) begin
      err_count++;
      $display("[TB] FAIL latency_count: got lat0=%0d lat3=%0d writes, want 256 256", obs0_q.size(), obs3_q.size());
    end
    for (int i = 0; i < 256 && i < obs0_q.size() && i < obs3_q.size(); i++) begin
      cmp_count++;
      if (obs0_q[i] !== (8'(i) ^ 8'h5A) || obs3_q[i] !== (8'(i) ^ 8'h5A)) begin
        err_count++;
        $display("[TB] FAIL latency_data[%0d]: got lat0=%h lat3=%h, want %h", i, obs0_q[i], obs3_q[i], 8'(i) ^ 8'h5A);
      end
    end
  endtask

  initial begin
    active_cnt  = 0;
    done_cnt    = 0;
    overlap_cnt = 0;
    act0_cnt    = 0;
    act3_cnt    = 0;
    test_reset();
    test_page_copy();
    test_offset();
    test_reset_mid();
    test_back_to_back();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite DMA engine that sits directly upstream of the memory decoder, on the CPU-side bus.
- Detects a CPU write to $4014, halts the CPU and takes the bus.
- Copies 256 bytes from CPU page {data,8'h00}..{data,8'hFF} into sprite RAM by issuing $2004 writes, which auto-increment the sprite RAM address.
- Releases the bus when the copy is complete.

Parameters:
- RD_LATENCY, 1: cycles from read address presented to valid bus_data_in. Legal range 0..3.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cpu_addr  in  16  CPU address bus, used for trigger decode.
- cpu_data_in  in  8  CPU write data; the page number on a $4014 write.
- cpu_write_en  in  1  CPU write strobe.
- bus_data_in  in  8  read data returned by the memory decoder (its cpu_data_out).
- dma_active  out  1  DMA owns the bus; the bus mux selects dma_* signals when high.
- cpu_halt  out  1  stalls the CPU; identical timing to dma_active.
- dma_addr  out  16  address driven to the memory decoder.
- dma_data_out  out  8  write data driven to the memory decoder.
- dma_write_en  out  1  write strobe to the memory decoder.
- dma_read_en  out  1  read strobe to the memory decoder.
- dma_done  out  1  one-cycle pulse after the final byte is written.

Behaviour:
- Reset: asynchronous, active-high, no wait for a clock edge.
  - All outputs go to 0: dma_active, cpu_halt, dma_addr=16'h0000, dma_data_out=8'h00, dma_write_en, dma_read_en, dma_done.
  - State returns to IDLE; page, index and latch registers clear.
  - Reset mid-transfer abandons the copy immediately. No further writes occur, and no dma_done pulse is issued.
- Trigger: in IDLE, a rising clk edge with cpu_write_en=1 and cpu_addr==16'h4014 latches page=cpu_data_in and index=0, and moves to READ.
  - A $4014 write while not IDLE is ignored (the CPU is halted, so this is a protocol error only).
- States:
  - IDLE: outputs inactive, dma_addr=0.
  - READ: one cycle.
    - dma_active=cpu_halt=1, dma_addr={page,index}, dma_read_en=1.
    - If RD_LATENCY=0, latch bus_data_in at the closing edge and go to WRITE; else go to WAIT.
  - WAIT: RD_LATENCY cycles.
    - dma_addr held at {page,index}, dma_read_en=0.
    - bus_data_in is latched at the closing edge of the last WAIT cycle, then go to WRITE.
  - WRITE: one cycle.
    - dma_addr=16'h2004, dma_data_out=latched byte, dma_write_en=1.
    - If index==8'hFF, go to IDLE and assert dma_done for the following cycle.
    - Else index=index+1 and go to READ.
- Timing:
  - dma_active and cpu_halt go high the cycle after the trigger edge and stay high continuously through the final WRITE cycle.
  - Per byte: 2+RD_LATENCY cycles. Total: 256*(2+RD_LATENCY) cycles, i.e. 768 with the default.
- Arithmetic:
  - index is 8 bits; the terminal check is index==8'hFF, with no wrap past 255.
  - Source address is {page,index}, so the source never crosses its 256-byte page.
- Not modified by this block: the sprite RAM start address. A copy starts wherever $2003 last left it and wraps mod 256 inside the decoder.
- dma_read_en and dma_write_en are never high in the same cycle.
- Page number is unrestricted; pages $20..$3F read PPU registers by design and are not filtered.
- dma_done is high only in the cycle after the final WRITE. A new trigger is accepted in that same cycle, since the state is already IDLE.

Test Plan:
- Page copy: preload CPU RAM $0200+i = i^8'h5A, write $00 to $2003, write $02 to $4014 → 256 writes to $2004 with data 8'h5A,8'h5B,...; sprite RAM[i]=i^8'h5A; dma_active high for exactly 768 cycles; one dma_done pulse.
- Cycle check (RD_LATENCY=1): the first bus cycles after the trigger are addr $0200 with read_en=1, then $0200 held, then $2004 with write_en=1, then $0201 → exact sequence matches; read_en and write_en are never both 1.
- RD_LATENCY=0 and 3 builds: same copy as the first scenario → dma_active length is 512 and 1280 cycles respectively; data correct.
- Offset start: write $80 to $2003, DMA page $03 → sprite RAM[(0x80+i)&0xFF] = CPU $0300+i; sprite address wraps through $FF to $00.
- Reset at cycle 100 of the transfer → all outputs 0 in the same cycle; no dma_done; a later $4014 write starts a clean copy from index 0.
- Retrigger: a $4014 write forced during an active DMA → ignored, with page and index unchanged. A $4014 write in the dma_done cycle → a new transfer starts on the next cycle.
